reaction_timer_ctrl: RTL and testbench

//  Trial sequencer for the reaction-timer datapath. Edge-detects the start/stop button.

---
 rtl/reaction_timer_ctrl.sv | 134 +++++++++++++
 tb/tb_reaction_timer_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/reaction_timer_ctrl.sv
// Reaction-timer trial sequencer: random pre-go delay, reaction count, false-start/timeout detection.
// Optional best-time tracking is built when BEST_TIME_EN is defined.
module reaction_timer_ctrl #(
  parameter int CNT_W      = 32,
  parameter int DELAY_MIN  = 1000,
  parameter int DELAY_BITS = 10,
  parameter int TIMEOUT    = 100000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ss,
  output logic             go,
  output logic             capture,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  output logic             timeout,
  output logic             false_start,
  output logic             busy,
  output logic [CNT_W-1:0] best
);

  typedef enum logic [2:0] {IDLE, ARM, GO, DONE, FAULT} state_t;

  localparam logic [CNT_W-1:0] DLY_BASE = CNT_W'(DELAY_MIN);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TMO_VAL  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t           state;
  logic             ss_q;
  logic             press;
  logic [15:0]      lfsr;
  logic [CNT_W-1:0] dly;
  logic [CNT_W-1:0] rt;
  logic [CNT_W-1:0] delay_load;

  assign press      = ss & ~ss_q;
  assign delay_load = DLY_BASE + CNT_W'(lfsr[DELAY_BITS-1:0]);

  // Free-running Fibonacci LFSR, taps 16,14,13,11; the seed keeps it off the all-zero lockup.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ss_q <= 1'b0;
      lfsr <= 16'hACE1;
    end else begin
      ss_q <= ss;
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      go           <= 1'b0;
      busy         <= 1'b0;
      capture      <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      timeout      <= 1'b0;
      false_start  <= 1'b0;
      dly          <= '0;
      rt           <= '0;
    end else begin
      capture <= 1'b0;
      case (state)
        IDLE: if (press) begin
          state <= ARM;
          busy  <= 1'b1;
          dly   <= delay_load;
        end
        ARM: begin
          // A press ends the trial even on the cycle the delay expires.
          if (press) begin
            state       <= FAULT;
            busy        <= 1'b0;
            false_start <= 1'b1;
          end else if (dly == '0) begin
            state <= GO;
            go    <= 1'b1;
            rt    <= '0;
          end else begin
            dly <= dly - ONE;
          end
        end
        GO: begin
          if (press) begin
            state        <= DONE;
            go           <= 1'b0;
            busy         <= 1'b0;
            result       <= rt;
            capture      <= 1'b1;
            result_valid <= 1'b1;
            timeout      <= 1'b0;
          end else if (rt == TMO_LAST) begin
            state        <= DONE;
            go           <= 1'b0;
            busy         <= 1'b0;
            result       <= TMO_VAL;
            capture      <= 1'b1;
            result_valid <= 1'b1;
            timeout      <= 1'b1;
          end else begin
            rt <= rt + ONE;
          end
        end
        DONE: if (press) begin
          state        <= ARM;
          busy         <= 1'b1;
          dly          <= delay_load;
          result_valid <= 1'b0;
          timeout      <= 1'b0;
        end
        FAULT: if (press) begin
          state       <= IDLE;
          false_start <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BEST_TIME_EN
  // Updated on the same edge that captures a pressed (non-timeout) result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      best <= '1;
    else if (state == GO && press && rt < best)
      best <= rt;
  end
`else
  assign best = '1;
`endif

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Directed bench for reaction_timer_ctrl with DELAY_MIN=4, DELAY_BITS=2, TIMEOUT=20.
module tb_reaction_timer_ctrl;
  localparam int CNT_W = 32;
  localparam int DMIN  = 4;
  localparam int TMO   = 20;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             ss = 1'b0;
  logic             go, capture, result_valid, timeout, false_start, busy;
  logic [CNT_W-1:0] result, best;
  logic [15:0]      m;
  int               checks = 0;
  int               failures = 0;

  reaction_timer_ctrl #(.CNT_W(CNT_W), .DELAY_MIN(DMIN), .DELAY_BITS(2), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .ss(ss), .go(go), .capture(capture), .result(result),
    .result_valid(result_valid), .timeout(timeout), .false_start(false_start), .busy(busy),
    .best(best)
  );

  always #5 clk = ~clk;

  // Reference LFSR used only to predict the random delay addend.
  always @(posedge clk or negedge reset_n)
    if (!reset_n) m <= 16'hACE1;
    else          m <= {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press();
    ss = 1'b1;
    tick();
    ss = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_to_go(input string tag);
    int d;
    d = DMIN + int'(m[1:0]);
    press();
    check({tag, "_busy"}, 32'(busy), 1);
    repeat (d) tick();
    check({tag, "_go_early"}, 32'(go), 0);
    tick();
    check({tag, "_go"}, 32'(go), 1);
  endtask

  task automatic react(input string tag, input int n);
    repeat (n) tick();
    press();
    check({tag, "_result"}, result, 32'(n));
    check({tag, "_capture"}, 32'(capture), 1);
    check({tag, "_valid"}, 32'(result_valid), 1);
    check({tag, "_tmo"}, 32'(timeout), 0);
    check({tag, "_go_off"}, 32'(go), 0);
    tick();
    check({tag, "_capture_off"}, 32'(capture), 0);
    check({tag, "_valid_hold"}, 32'(result_valid), 1);
  endtask

  task automatic timeout_trial(input string tag);
    run_to_go(tag);
    repeat (TMO - 1) tick();
    check({tag, "_go_last"}, 32'(go), 1);
    tick();
    check({tag, "_go_off"}, 32'(go), 0);
    check({tag, "_result"}, result, 32'(TMO));
    check({tag, "_tmo"}, 32'(timeout), 1);
    check({tag, "_capture"}, 32'(capture), 1);
    check({tag, "_valid"}, 32'(result_valid), 1);
    tick();
    check({tag, "_capture_off"}, 32'(capture), 0);
  endtask

  function automatic logic [31:0] exp_best(input logic [31:0] v);
`ifdef BEST_TIME_EN
    return v;
`else
    return 32'hFFFF_FFFF;
`endif
  endfunction

  initial begin
    int d;
    // Reset state
    tick();
    tick();
    check("rst_go", 32'(go), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_capture", 32'(capture), 0);
    check("rst_valid", 32'(result_valid), 0);
    check("rst_result", result, 0);
    check("rst_fs", 32'(false_start), 0);
    check("rst_best", best, 32'hFFFF_FFFF);
    reset_n = 1'b1;

    // Async reset while in GO
    run_to_go("t1");
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check("t1_async_go", 32'(go), 0);
    check("t1_async_busy", 32'(busy), 0);
    check("t1_async_capture", 32'(capture), 0);
    check("t1_async_valid", 32'(result_valid), 0);
    tick();
    reset_n = 1'b1;

    // First press after reset: lfsr[1:0]=1 so D=5, go after 6 ARM cycles
    press();
    check("t2_busy", 32'(busy), 1);
    repeat (5) tick();
    check("t2_go_early", 32'(go), 0);
    tick();
    check("t2_go", 32'(go), 1);
    react("t2", 3);

    // False start from mid-ARM
    press();
    check("t3_rearm_valid", 32'(result_valid), 0);
    check("t3_rearm_result", result, 3);
    tick();
    tick();
    press();
    check("t3a_fs", 32'(false_start), 1);
    check("t3a_busy", 32'(busy), 0);
    repeat (10) tick();
    check("t3a_go_never", 32'(go), 0);
    check("t3a_fs_hold", 32'(false_start), 1);
    press();
    check("t3a_fs_clr", 32'(false_start), 0);
    tick();

    // False start on the cycle dly reaches zero
    d = DMIN + int'(m[1:0]);
    press();
    repeat (d) tick();
    press();
    check("t3b_fs", 32'(false_start), 1);
    check("t3b_go", 32'(go), 0);
    tick();
    check("t3b_go_never", 32'(go), 0);
    press();
    check("t3b_fs_clr", 32'(false_start), 0);
    check("t3b_busy", 32'(busy), 0);
    tick();

    // Timeout from IDLE
    timeout_trial("t4");

    // ss held high through GO must not stop the trial
    d = DMIN + int'(m[1:0]);
    ss = 1'b1;
    tick();
    repeat (d) tick();
    tick();
    check("t5_go", 32'(go), 1);
    repeat (TMO) tick();
    check("t5_go_off", 32'(go), 0);
    check("t5_tmo", 32'(timeout), 1);
    check("t5_result", result, 32'(TMO));
    ss = 1'b0;
    tick();
    press();
    check("t5_rearm_busy", 32'(busy), 1);
    check("t5_rearm_valid", 32'(result_valid), 0);
    check("t5_rearm_tmo", 32'(timeout), 0);
    check("t5_rearm_result", result, 32'(TMO));

    // Best time: 7, 3, timeout, 5
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("t6_best_rst", best, 32'hFFFF_FFFF);
    run_to_go("t6a");
    react("t6a", 7);
    check("t6a_best", best, exp_best(7));
    run_to_go("t6b");
    react("t6b", 3);
    check("t6b_best", best, exp_best(3));
    timeout_trial("t6c");
    check("t6c_best", best, exp_best(3));
    run_to_go("t6d");
    react("t6d", 5);
    check("t6d_best", best, exp_best(3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
